// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead byte FIFO between the UART TX data register
// write path and the UART serializer.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   wr_en, wr_data    push request and byte from MMIO TX data writes
//   flush             synchronous discard of all stored entries
//   clr_overflow      clears the sticky overflow flag
//   full, empty       count == DEPTH / count == 0
//   count             stored entries, 0..DEPTH
//   overflow          sticky, set when a push is dropped
//   tx_data           oldest entry, 0 when empty
//   tx_data_valid     !empty
//   tx_data_ready     serializer accepts tx_data this cycle
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    input  logic             clr_overflow,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_data_valid,
    input  logic             tx_data_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             pop;
    logic             push;
    logic             drop;

    // Status comes from the registered count only.
    assign full          = (cnt == CW'(DEPTH));
    assign empty         = (cnt == '0);
    assign count         = cnt;
    assign tx_data_valid = !empty;
    assign overflow      = ovf;

    // Show-ahead: head entry is visible with no read latency.
    assign tx_data = empty ? '0 : mem[rp];

    assign pop  = tx_data_valid & tx_data_ready;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign push = wr_en & (!full | pop);
    assign drop = wr_en & full & !pop & !flush;

    // Storage is not reset; flush and reset only move pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_overflow) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a queue-based
// reference model; directed cases plus a randomized wrap-around stream.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             flush = 1'b0;
    logic             clr_overflow = 1'b0;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [WIDTH-1:0] tx_data;
    logic             tx_data_valid;
    logic             tx_data_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] sb [$];
    bit               ovf_m = 1'b0;
    int               n_push = 0;
    int               n_pop  = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the edge.
    task automatic step(input bit w, input logic [WIDTH-1:0] d,
                        input bit rdy, input bit fl, input bit clr);
        wr_en         = w;
        wr_data       = d;
        tx_data_ready = rdy;
        flush         = fl;
        clr_overflow  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 0);
    endtask

    // Reference model + monitor: evaluated mid-cycle with stable inputs.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ovf_m  = 1'b0;
            n_push = 0;
            n_pop  = 0;
        end else begin
            chk("count", int'(count), sb.size());
            chk("count_vs_flow", int'(count), n_push - n_pop);
            chk("empty", int'(empty), int'(sb.size() == 0));
            chk("full", int'(full), int'(sb.size() == DEPTH));
            chk("valid", int'(tx_data_valid), int'(sb.size() != 0));
            chk("overflow", int'(overflow), int'(ovf_m));
            if (sb.size() == 0) begin
                chk("tx_data_empty", int'(tx_data), 0);
            end
            if (flush) begin
                sb.delete();
                n_push = 0;
                n_pop  = 0;
            end else begin
                bit popm;
                popm = (sb.size() != 0) && tx_data_ready;
                if (popm) begin
                    chk("tx_data_out", int'(tx_data), int'(sb[0]));
                    void'(sb.pop_front());
                    n_pop++;
                end
                if (wr_en && (sb.size() < DEPTH)) begin
                    sb.push_back(wr_data);
                    n_push++;
                end else if (wr_en) begin
                    ovf_m = 1'b1;
                end
            end
            if (clr_overflow && !(wr_en && !flush && sb.size() == DEPTH
                                  && !tx_data_ready)) begin
                ovf_m = ovf_m && (wr_en && !flush && full && !tx_data_ready);
            end
        end
    end

    initial begin
        int np;
        int guard;
        logic [WIDTH-1:0] bytes3 [3];
        bytes3[0] = 8'h41;
        bytes3[1] = 8'h42;
        bytes3[2] = 8'h43;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_valid", int'(tx_data_valid), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        repeat (5) step(0, 8'h00, 1, 0, 0);
        chk("idle_ready_count", int'(count), 0);
        chk("idle_ready_empty", int'(empty), 1);

        // Three bytes, held then drained
        for (int i = 0; i < 3; i++) step(1, bytes3[i], 0, 0, 0);
        chk("three_count", int'(count), 3);
        chk("three_head", int'(tx_data), 8'h41);
        repeat (3) step(0, 8'h00, 1, 0, 0);
        chk("three_drained_empty", int'(empty), 1);
        chk("three_drained_data", int'(tx_data), 0);

        // Fill, overflow, clear, drain
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), DEPTH);
        step(1, 8'hFF, 0, 0, 0);
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_count", int'(count), DEPTH);
        step(0, 8'h00, 0, 0, 1);
        chk("clr_overflow", int'(overflow), 0);
        repeat (DEPTH) step(0, 8'h00, 1, 0, 0);
        chk("drain_empty", int'(empty), 1);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        chk("pp_head", int'(tx_data), 8'h00);
        step(1, 8'hAA, 1, 0, 0);
        chk("pp_count", int'(count), DEPTH);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_head_next", int'(tx_data), 8'h01);
        repeat (DEPTH) step(0, 8'h00, 1, 0, 0);
        chk("pp_drain_empty", int'(empty), 1);

        // Randomized wrap-around stream
        np = 0;
        guard = 0;
        while (np < 40 && guard < 2000) begin
            bit w;
            w = ($urandom_range(0, 1) == 1) && (sb.size() < DEPTH);
            step(w, 8'($urandom), $urandom_range(0, 1) == 1, 0, 0);
            if (w) np++;
            guard++;
        end
        chk("stream_pushes", np, 40);
        guard = 0;
        while (sb.size() != 0 && guard < 64) begin
            step(0, 8'h00, 1, 0, 0);
            guard++;
        end
        chk("stream_drain_empty", int'(empty), 1);

        // Flush with a concurrent push and pop
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        chk("pre_flush_count", int'(count), 5);
        step(1, 8'h99, 1, 1, 0);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        idle();
        chk("flush_no_store", int'(count), 0);
        chk("flush_tx_data", int'(tx_data), 0);

        // Overflow then async reset mid-stream
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("pre_rst_overflow", int'(overflow), 1);
        repeat (3) step(1, 8'($urandom), 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_valid", int'(tx_data_valid), 0);
        chk("arst_tx_data", int'(tx_data), 0);
        chk("arst_overflow", int'(overflow), 0);
        wr_en         = 1'b0;
        tx_data_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 8'h5A, 0, 0, 0);
        chk("post_rst_head", int'(tx_data), 8'h5A);
        step(0, 8'h00, 1, 0, 0);
        idle();
        chk("post_rst_empty", int'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
